// File: rtl/cpu_word_mem_responder.sv
// Fixed-latency, word-addressed memory behind the cache_top CPU request/response port.
// Serves one request at a time; usable as a golden reference next to the real cache.
module cpu_word_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_rw,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_resp_err
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                req_rw;
    logic                req_oor;
    logic [IDX_W-1:0]    req_idx;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;
    logic [DATA_W-1:0]   mem [MEM_WORDS];
    logic [DATA_W-1:0]   merged;
    logic [ADDR_W-3:0]   waddr;
    logic                addr_oor;
    logic                accept;
    logic                access;
    logic                unused_addr_lsb;

    // Byte offset bits never matter: accesses are always word-aligned.
    assign unused_addr_lsb = ^cpu_addr[1:0];
    assign waddr           = cpu_addr[ADDR_W-1:2];
    // Range check on the full word address so high addresses never alias into the array.
    assign addr_oor        = ({1'b0, waddr} >= (ADDR_W-1)'(MEM_WORDS));

    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        accept        = 1'b0;
        access        = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        merged = mem[req_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            req_rw         <= 1'b0;
            req_oor        <= 1'b0;
            req_idx        <= '0;
            req_wdata      <= '0;
            req_wstrb      <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_resp_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cpu_resp_valid <= access;
            if (accept) begin
                req_rw    <= cpu_req_rw;
                req_oor   <= addr_oor;
                req_idx   <= cpu_addr[2 +: IDX_W];
                req_wdata <= cpu_wdata;
                req_wstrb <= cpu_wstrb;
                cnt       <= CNT_W'(LATENCY);
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                cpu_resp_err <= req_oor;
                if (req_oor)     cpu_rdata <= '0;
                else if (req_rw) cpu_rdata <= merged;
                else             cpu_rdata <= mem[req_idx];
            end
        end
    end

    // Array is deliberately unreset; reset forces IDLE so a pending write never commits.
    always_ff @(posedge clk) begin
        if (access && req_rw && !req_oor) mem[req_idx] <= merged;
    end

endmodule

// File: tb/tb_cpu_word_mem_responder.sv
// Directed bench for cpu_word_mem_responder: vector table plus hand sequences for
// back-pressure, mid-transaction reset and the LATENCY=1 build.
module tb_cpu_word_mem_responder;
    logic        clk, rst_n;
    logic        valid, ready, rw, resp_valid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        l1_valid, l1_ready, l1_rw, l1_resp_valid, l1_err;
    logic [31:0] l1_addr, l1_wdata, l1_rdata;
    logic [3:0]  l1_wstrb;

    int checks = 0;
    int errors = 0;

    cpu_word_mem_responder #(.LATENCY(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(valid), .cpu_req_ready(ready), .cpu_req_rw(rw),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_wstrb(wstrb),
        .cpu_resp_valid(resp_valid), .cpu_rdata(rdata), .cpu_resp_err(err)
    );

    cpu_word_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(l1_valid), .cpu_req_ready(l1_ready), .cpu_req_rw(l1_rw),
        .cpu_addr(l1_addr), .cpu_wdata(l1_wdata), .cpu_wstrb(l1_wstrb),
        .cpu_resp_valid(l1_resp_valid), .cpu_rdata(l1_rdata), .cpu_resp_err(l1_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the LATENCY=5 DUT; returns data, err and accept-to-resp edge count.
    task automatic txn(input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                       input logic [3:0] t_strb, output logic [31:0] t_rd, output logic t_err,
                       output int lat);
        int b = 0;
        @(negedge clk);
        while (!ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        valid = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; wstrb = t_strb;
        @(posedge clk);
        #1 valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        t_rd  = rdata;
        t_err = err;
        @(posedge clk);
        #1 chk("resp_pulse_width", {31'b0, resp_valid}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [14:1] got_rdy, got_rsp;
    int          nresp;

    initial begin
        vecs[0]  = '{1'b1, 32'h44,   32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h44,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h44,   32'h000000AA, 4'h1, 1'b1, 32'hDEADBEAA, 1'b0};
        vecs[3]  = '{1'b0, 32'h44,   32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h44,   32'h11223344, 4'hA, 1'b1, 32'h11AD33AA, 1'b0};
        vecs[5]  = '{1'b0, 32'h44,   32'h0,        4'h0, 1'b1, 32'h11AD33AA, 1'b0};
        vecs[6]  = '{1'b1, 32'h44,   32'hFFFFFFFF, 4'h0, 1'b1, 32'h11AD33AA, 1'b0};
        vecs[7]  = '{1'b0, 32'h44,   32'h0,        4'h0, 1'b1, 32'h11AD33AA, 1'b0};
        vecs[8]  = '{1'b1, 32'h0,    32'h55AA55AA, 4'hF, 1'b1, 32'h55AA55AA, 1'b0};
        vecs[9]  = '{1'b1, 32'h4000, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h55AA55AA, 1'b0};
        vecs[11] = '{1'b0, 32'h4000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h46,   32'h0,        4'h0, 1'b1, 32'h11AD33AA, 1'b0};

        valid = 0; rw = 0; addr = 0; wdata = 0; wstrb = 0;
        l1_valid = 0; l1_rw = 0; l1_addr = 0; l1_wdata = 0; l1_wstrb = 0;

        // T1: reset
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_ready", {31'b0, ready}, 32'h1);

        // T2/T3/T5 vector table
        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd5);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // T4: valid held high across BUSY/RESP
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h48; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        @(posedge clk);
        #1 addr = 32'h4C; wdata = 32'h5A5A5A5A;
        nresp = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            got_rdy[k] = ready;
            got_rsp[k] = resp_valid;
            if (resp_valid) nresp++;
            if (k == 7) valid = 1'b0;
        end
        chk("hold_ready_trace", {18'b0, got_rdy}, {18'b0, 14'b11000000100000});
        chk("hold_resp_trace", {18'b0, got_rsp}, {18'b0, 14'b00100000010000});
        chk("hold_resp_count", nresp, 32'd2);
        txn(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
        chk("hold_0x44_intact", rd, 32'h11AD33AA);
        txn(1'b0, 32'h48, 32'h0, 4'h0, rd, er, lat);
        chk("hold_0x48", rd, 32'hA5A5A5A5);
        txn(1'b0, 32'h4C, 32'h0, 4'h0, rd, er, lat);
        chk("hold_0x4C", rd, 32'h5A5A5A5A);

        // T6: reset during BUSY drops the write
        @(negedge clk);
        valid = 1'b1; rw = 1'b1; addr = 32'h44; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrst_ready", {31'b0, ready}, 32'h1);
        nresp = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (resp_valid) nresp++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 if (resp_valid) nresp++;
        end
        chk("midrst_no_resp", nresp, 32'd0);
        chk("midrst_ready_after", {31'b0, ready}, 32'h1);
        txn(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
        chk("midrst_0x44_prior", rd, 32'h11AD33AA);

        // LATENCY=1 build: write then read 0x44
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("l1_%0d_ready", i), {31'b0, l1_ready}, 32'h1);
            l1_valid = 1'b1; l1_rw = (i == 0); l1_addr = 32'h44;
            l1_wdata = 32'hDEADBEEF; l1_wstrb = 4'hF;
            @(posedge clk);
            #1 l1_valid = 1'b0;
            chk($sformatf("l1_%0d_no_early_resp", i), {31'b0, l1_resp_valid}, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("l1_%0d_resp", i), {31'b0, l1_resp_valid}, 32'h1);
            chk($sformatf("l1_%0d_rdata", i), l1_rdata, 32'hDEADBEEF);
            chk($sformatf("l1_%0d_err", i), {31'b0, l1_err}, 32'h0);
            @(posedge clk);
            #1 chk($sformatf("l1_%0d_pulse", i), {31'b0, l1_resp_valid}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
